result_collector: RTL and testbench
===================================

Name: result_collector

Overview:
Downstream consumer of the Mandelbrot engine array. Arbitrates round-robin among engines raising service_req, drives the matching req_ack line, and samples the shared 27-bit tri-state result bus {x[9:0], y[8:0], iter[7:0]}. Converts (x,y) to a linear frame-buffer address and issues a single-cycle write of the iteration count to the frame buffer RAM. Tracks per-frame completion.

Parameters:
NUM_ENGINES, 16, number of engines on the shared result bus (2..64)
H_RES, 640, visible pixels per line
V_RES, 480, visible lines per frame
FB_ADDR_W, 19, frame-buffer address width (must satisfy 2^FB_ADDR_W >= H_RES*V_RES)

Ports:
Engine_CLK  in  1  system/engine clock, rising edge
eRST  in  1  reset
service_req  in  NUM_ENGINES  per-engine "result ready" request
req_ack  out  NUM_ENGINES  one-hot grant; enables that engine onto result_bus
result_bus  in  27  shared bus: [26:17] x, [16:8] y, [7:0] iterations
frame_start  in  1  one-cycle pulse; clears pixel_count, frame_done, range_err
fb_we  out  1  frame-buffer write strobe, one cycle per result
fb_addr  out  FB_ADDR_W  y*H_RES + x
fb_data  out  8  iteration count
pixel_count  out  FB_ADDR_W  pixels written since last frame_start
frame_done  out  1  sticky; pixel_count reached H_RES*V_RES
range_err  out  1  sticky; result with x>=H_RES or y>=V_RES received
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset eRST, asynchronous, active-high; clock Engine_CLK. Reset: req_ack=0, fb_we=0, fb_addr=0, fb_data=0, pixel_count=0, frame_done=0, range_err=0, busy=0, rr pointer=0, state=IDLE.
- FSM states: IDLE, ACK, CAPTURE, WRITE, RELEASE.
- IDLE: if service_req!=0, grant g = first requester at or above pointer, wrapping modulo NUM_ENGINES; register g; req_ack[g]<=1; -> ACK. Else stay.
- ACK: req_ack[g] held; one bus-settle cycle; -> CAPTURE.
- CAPTURE: req_ack[g] held; register result_bus; compute address y*H_RES+x (shift-add allowed, fully registered); in_range = (x<H_RES)&&(y<V_RES); -> WRITE.
- WRITE: req_ack<=0; if in_range: fb_we=1 one cycle, fb_addr/fb_data valid same cycle, pixel_count+=1; else no write, range_err<=1. -> RELEASE.
- RELEASE: wait until service_req[g]==0 (engine drops it after seeing ack); then pointer<=(g+1) mod NUM_ENGINES; -> IDLE.
- Latency: service_req seen in IDLE at cycle 0 -> req_ack[g] high cycles 1-2 -> fb_we cycle 3. Max throughput one result per 5 cycles.
- req_ack is always one-hot or zero; never two engines on the bus.
- Requests arriving while busy wait; not lost (engines hold service_req).
- frame_done set the cycle pixel_count becomes H_RES*V_RES; pixel_count saturates there (further writes still issued, count holds).
- frame_start simultaneous with a write: frame_start wins for flags; the write counts toward the new frame (pixel_count=1 after).
- fb_addr/fb_data hold last value when fb_we=0.
- Reset mid-operation: req_ack and fb_we drop immediately (async); partial results discarded.
- Unknown/out-of-range state -> IDLE with req_ack=0.

Decomposition:
- Shared constants header (mandel_constants): H_RES, V_RES, FB_ADDR_W, RESULT_W=27, bus field bit positions, NUM_ENGINES default.
- One sub-module: rr_arbiter — combinational round-robin pick of next requester given pointer and request vector; outputs index and valid. FSM, address calc, counters stay in result_collector.

Test Plan:
- Engine 3 requests, bus x=5,y=2,iter=0x2A -> req_ack=0x0008 cycles 1-2, fb_we cycle 3, fb_addr=1285, fb_data=0x2A, pixel_count=1.
- Engines 0 and 1 request together, pointer 0 -> engine 0 served first, then engine 1; pointer ends at 2; req_ack never two bits high.
- All 16 engines hold requests continuously -> grants 0,1,...,15,0 in order, one fb_we per 5 cycles.
- x=639,y=479 -> fb_addr=307199 written; x=640,y=0 -> no fb_we, range_err=1, pixel_count unchanged.
- 307200 in-range writes -> frame_done=1 at last write; frame_start pulse -> frame_done=0, pixel_count=0, range_err=0.
- eRST asserted while in CAPTURE -> req_ack=0 and fb_we=0 immediately, state IDLE, pointer 0, no write issued.

Source files
------------

// File: rtl/result_collector_pkg.sv
// Shared Mandelbrot result-path constants: frame geometry defaults,
// result bus layout and the collector FSM state type.
package result_collector_pkg;

    localparam int NUM_ENGINES_DEF = 16;
    localparam int H_RES_DEF       = 640;
    localparam int V_RES_DEF       = 480;
    localparam int FB_ADDR_W_DEF   = 19;

    // Result bus layout: [26:17] x, [16:8] y, [7:0] iteration count
    localparam int RESULT_W = 27;
    localparam int X_W      = 10;
    localparam int Y_W      = 9;
    localparam int ITER_W   = 8;
    localparam int X_LSB    = 17;
    localparam int Y_LSB    = 8;
    localparam int ITER_LSB = 0;

    typedef struct packed {
        logic [X_W-1:0]    x;
        logic [Y_W-1:0]    y;
        logic [ITER_W-1:0] iter;
    } result_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACK     = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_RELEASE = 3'd4
    } rc_state_t;

endpackage

// File: rtl/result_collector_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above the pointer,
// wrapping modulo NUM_ENGINES.
module rr_arbiter
    import result_collector_pkg::*;
#(
    parameter int NUM_ENGINES = NUM_ENGINES_DEF,
    parameter int IDX_W       = $clog2(NUM_ENGINES)
) (
    input  logic [IDX_W-1:0]       i_ptr,
    input  logic [NUM_ENGINES-1:0] i_req,
    output logic [IDX_W-1:0]       o_idx,
    output logic                   o_valid
);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_cand;

    // Scan candidates ptr, ptr+1, ... (mod N) and keep the first requester
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_sum   = '0;
        w_cand  = '0;
        for (int k = 0; k < NUM_ENGINES; k++) begin
            w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(NUM_ENGINES)) begin
                w_sum = w_sum - (IDX_W+1)'(NUM_ENGINES);
            end
            w_cand = w_sum[IDX_W-1:0];
            if (!o_valid && i_req[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/result_collector.sv
// Result collector: round-robin service of engines on the shared result bus,
// frame-buffer write of each in-range pixel, per-frame pixel accounting.
module result_collector
    import result_collector_pkg::*;
#(
    parameter int NUM_ENGINES = NUM_ENGINES_DEF,
    parameter int H_RES       = H_RES_DEF,
    parameter int V_RES       = V_RES_DEF,
    parameter int FB_ADDR_W   = FB_ADDR_W_DEF
) (
    input  logic                   Engine_CLK,
    input  logic                   eRST,
    input  logic [NUM_ENGINES-1:0] service_req,
    output logic [NUM_ENGINES-1:0] req_ack,
    input  logic [RESULT_W-1:0]    result_bus,
    input  logic                   frame_start,
    output logic                   fb_we,
    output logic [FB_ADDR_W-1:0]   fb_addr,
    output logic [ITER_W-1:0]      fb_data,
    output logic [FB_ADDR_W-1:0]   pixel_count,
    output logic                   frame_done,
    output logic                   range_err,
    output logic                   busy
);

    localparam int IDX_W = $clog2(NUM_ENGINES);
    localparam logic [FB_ADDR_W-1:0] PIX_TOTAL = FB_ADDR_W'(H_RES * V_RES);

    rc_state_t r_state;
    rc_state_t w_next_state;

    logic [IDX_W-1:0]     r_ptr;
    logic [IDX_W-1:0]     r_gnt;
    logic                 r_in_range;
    logic [FB_ADDR_W-1:0] r_fb_addr;
    logic [ITER_W-1:0]    r_fb_data;
    logic [FB_ADDR_W-1:0] r_pix;
    logic                 r_done;
    logic                 r_err;

    logic [IDX_W-1:0]     w_arb_idx;
    logic                 w_arb_valid;
    logic                 w_ack_en;
    logic                 w_we;
    logic                 w_busy;
    result_t              w_res;
    logic [FB_ADDR_W-1:0] w_addr;
    logic                 w_in_range;

    rr_arbiter #(
        .NUM_ENGINES (NUM_ENGINES),
        .IDX_W       (IDX_W)
    ) u_arb (
        .i_ptr   (r_ptr),
        .i_req   (service_req),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_valid)
    );

    assign w_res      = result_t'(result_bus);
    // Constant multiply reduces to shift-add; result is registered in CAPTURE
    assign w_addr     = FB_ADDR_W'(w_res.y) * FB_ADDR_W'(H_RES) + FB_ADDR_W'(w_res.x);
    assign w_in_range = (32'(w_res.x) < 32'(H_RES)) && (32'(w_res.y) < 32'(V_RES));

    // State register; async reset drops the grant and write strobe at once
    always_ff @(posedge Engine_CLK or posedge eRST) begin
        if (eRST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and per-state strobes
    always_comb begin
        w_next_state = ST_IDLE;
        w_ack_en     = 1'b0;
        w_we         = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_busy       = 1'b0;
                w_next_state = w_arb_valid ? ST_ACK : ST_IDLE;
            end
            ST_ACK: begin
                w_ack_en     = 1'b1;
                w_next_state = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                w_ack_en     = 1'b1;
                w_next_state = ST_WRITE;
            end
            ST_WRITE: begin
                w_we         = r_in_range;
                w_next_state = ST_RELEASE;
            end
            ST_RELEASE: begin
                w_next_state = service_req[r_gnt] ? ST_RELEASE : ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // One-hot grant decoded from the registered winner, only in ACK/CAPTURE
    always_comb begin
        req_ack = '0;
        if (w_ack_en) begin
            req_ack[r_gnt] = 1'b1;
        end
    end

    // Grant, pointer and captured pixel; fb_addr/fb_data only move on an in-range capture
    always_ff @(posedge Engine_CLK or posedge eRST) begin
        if (eRST) begin
            r_ptr      <= '0;
            r_gnt      <= '0;
            r_in_range <= 1'b0;
            r_fb_addr  <= '0;
            r_fb_data  <= '0;
        end else begin
            if (r_state == ST_IDLE && w_arb_valid) begin
                r_gnt <= w_arb_idx;
            end
            if (r_state == ST_CAPTURE) begin
                r_in_range <= w_in_range;
                if (w_in_range) begin
                    r_fb_addr <= w_addr;
                    r_fb_data <= w_res.iter;
                end
            end
            if (r_state == ST_RELEASE && !service_req[r_gnt]) begin
                r_ptr <= (r_gnt == IDX_W'(NUM_ENGINES - 1)) ? '0 : r_gnt + 1'b1;
            end
        end
    end

    // Frame accounting; frame_start overrides flags but a coincident write still counts
    always_ff @(posedge Engine_CLK or posedge eRST) begin
        if (eRST) begin
            r_pix  <= '0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else if (frame_start) begin
            r_pix  <= w_we ? FB_ADDR_W'(1) : '0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else if (w_we) begin
            if (r_pix < PIX_TOTAL) begin
                r_pix <= r_pix + FB_ADDR_W'(1);
                if (r_pix == PIX_TOTAL - FB_ADDR_W'(1)) begin
                    r_done <= 1'b1;
                end
            end
        end else if (r_state == ST_WRITE && !r_in_range) begin
            r_err <= 1'b1;
        end
    end

    assign fb_we       = w_we;
    assign fb_addr     = r_fb_addr;
    assign fb_data     = r_fb_data;
    assign pixel_count = r_pix;
    assign frame_done  = r_done;
    assign range_err   = r_err;
    assign busy        = w_busy;

endmodule

// File: tb/tb_result_collector.sv
// Bench for result_collector: reactive engine models on the shared bus,
// a transaction-level reference model, and per-cycle output comparison.
module tb_result_collector;

    localparam int NE  = 16;
    localparam int H   = 640;
    localparam int V   = 4;
    localparam int AW  = 12;
    localparam int TOT = H * V;

    logic          clk = 1'b0;
    logic          rst;
    logic [NE-1:0] svc;
    logic [NE-1:0] ack;
    logic [26:0]   bus;
    logic          fs;
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    data;
    logic [AW-1:0] pc;
    logic          fd;
    logic          re;
    logic          busy;

    always #5 clk = ~clk;

    result_collector #(
        .NUM_ENGINES (NE),
        .H_RES       (H),
        .V_RES       (V),
        .FB_ADDR_W   (AW)
    ) dut (
        .Engine_CLK  (clk),
        .eRST        (rst),
        .service_req (svc),
        .req_ack     (ack),
        .result_bus  (bus),
        .frame_start (fs),
        .fb_we       (we),
        .fb_addr     (addr),
        .fb_data     (data),
        .pixel_count (pc),
        .frame_done  (fd),
        .range_err   (re),
        .busy        (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Engine side: pending results per engine, and whether it is mid-handshake
    logic [26:0] eq [NE][$];
    bit          acked [NE];

    // Reference model (transaction timeline)
    bit m_active;
    int m_g, m_t0, m_ptr;
    bit m_inr;
    int m_addr, m_data, m_pc;
    bit m_fd, m_re;

    // Observation logs
    int            grant_log[$];
    int            we_log[$];
    int            ack_cyc[$];
    int            ack_val[$];
    logic [NE-1:0] prev_ack = '0;

    // Stimulus controls
    bit fs_req        = 0;
    bit fs_at_write   = 0;
    bit rnd_fs        = 0;
    bit rst_at_capture = 0;
    int rst_hold      = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [26:0] mk(input int x, input int y, input int it);
        logic [9:0] xx;
        logic [8:0] yy;
        logic [7:0] ii;
        xx = x[9:0];
        yy = y[8:0];
        ii = it[7:0];
        return {xx, yy, ii};
    endfunction

    function automatic int rr_pick(input logic [NE-1:0] r, input int p);
        for (int k = 0; k < NE; k++) begin
            if (r[(p + k) % NE]) return (p + k) % NE;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_active = 0; m_ptr = 0; m_g = 0; m_t0 = 0; m_inr = 0;
        m_addr = 0; m_data = 0; m_pc = 0; m_fd = 0; m_re = 0;
    endtask

    task automatic model_step();
        bit wr, bad;
        int x, y;
        wr  = m_active && (cyc == m_t0 + 3) && m_inr;
        bad = m_active && (cyc == m_t0 + 3) && !m_inr;
        if (fs) begin
            m_pc = wr ? 1 : 0; m_fd = 0; m_re = 0;
        end else if (wr) begin
            if (m_pc < TOT) m_pc++;
            if (m_pc == TOT) m_fd = 1;
        end else if (bad) begin
            m_re = 1;
        end
        if (!m_active) begin
            if (svc != '0) begin
                m_g = rr_pick(svc, m_ptr); m_t0 = cyc; m_active = 1;
            end
        end else begin
            if (cyc == m_t0 + 2) begin
                x = int'(bus[26:17]);
                y = int'(bus[16:8]);
                m_inr = (x < H) && (y < V);
                if (m_inr) begin
                    m_addr = y * H + x;
                    m_data = int'(bus[7:0]);
                end
            end
            if (cyc >= m_t0 + 4 && !svc[m_g]) begin
                m_ptr = (m_g + 1) % NE;
                m_active = 0;
            end
        end
    endtask

    // One clock: compare outputs, react as the engines, advance the model
    task automatic cycle();
        logic [NE-1:0] e_ack;
        @(negedge clk);
        cyc++;
        e_ack = '0;
        if (m_active && (cyc == m_t0 + 1 || cyc == m_t0 + 2)) e_ack[m_g] = 1'b1;
        chk("req_ack", 64'(ack), 64'(e_ack));
        chk("ack_onehot", 64'($countones(ack) <= 1), 64'(1));
        chk("fb_we", 64'(we), 64'(m_active && cyc == m_t0 + 3 && m_inr));
        chk("busy", 64'(busy), 64'(m_active));
        chk("fb_addr", 64'(addr), 64'(m_addr));
        chk("fb_data", 64'(data), 64'(m_data));
        chk("pixel_count", 64'(pc), 64'(m_pc));
        chk("frame_done", 64'(fd), 64'(m_fd));
        chk("range_err", 64'(re), 64'(m_re));

        if (ack != '0 && prev_ack == '0) begin
            for (int i = 0; i < NE; i++) if (ack[i]) grant_log.push_back(i);
        end
        if (ack != '0) begin
            ack_cyc.push_back(cyc);
            ack_val.push_back(int'(ack));
        end
        if (we) we_log.push_back(cyc);
        prev_ack = ack;

        if (rst_at_capture && m_active && cyc == m_t0 + 2) begin
            rst = 1'b1;
            #1;
            chk("rst_async_ack", 64'(ack), 64'(0));
            chk("rst_async_we", 64'(we), 64'(0));
            chk("rst_async_busy", 64'(busy), 64'(0));
            model_reset();
            for (int i = 0; i < NE; i++) begin
                eq[i].delete();
                acked[i] = 0;
            end
            svc = '0;
            rst_at_capture = 0;
            rst_hold = 2;
            return;
        end

        if (rst_hold > 0) begin
            rst_hold--;
            if (rst_hold == 0) rst = 1'b0;
        end

        bus = 27'($urandom);
        for (int i = 0; i < NE; i++) begin
            if (ack[i]) begin
                svc[i] = 1'b0;
                acked[i] = 1;
                if (eq[i].size() > 0) bus = eq[i][0];
            end else if (acked[i] && !busy) begin
                void'(eq[i].pop_front());
                acked[i] = 0;
            end
            if (!acked[i]) svc[i] = (eq[i].size() > 0);
        end

        fs = 1'b0;
        if (fs_req) begin fs = 1'b1; fs_req = 0; end
        if (fs_at_write && m_active && cyc == m_t0 + 3) begin fs = 1'b1; fs_at_write = 0; end
        if (rnd_fs && $urandom_range(0, 39) == 0) fs = 1'b1;

        if (!rst) model_step();
    endtask

    function automatic bit all_idle();
        if (m_active || rst_hold > 0) return 0;
        for (int i = 0; i < NE; i++) if (eq[i].size() > 0 || acked[i]) return 0;
        return 1;
    endfunction

    task automatic run_idle(input int budget);
        int n = 0;
        while (!all_idle() && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_within_budget", 64'(n < budget), 64'(1));
        cycle();
        cycle();
    endtask

    initial begin
        int c0;
        rst = 1'b1; svc = '0; bus = '0; fs = 1'b0;
        for (int i = 0; i < NE; i++) acked[i] = 0;
        model_reset();
        repeat (3) cycle();
        chk("reset_req_ack", 64'(ack), 64'(0));
        chk("reset_fb_we", 64'(we), 64'(0));
        chk("reset_fb_addr", 64'(addr), 64'(0));
        chk("reset_pixel_count", 64'(pc), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        rst = 1'b0;
        cycle();

        // Two simultaneous requesters from pointer 0
        eq[0].push_back(mk(10, 1, 1));
        eq[1].push_back(mk(20, 1, 2));
        grant_log.delete();
        run_idle(100);
        chk("two_req_ngrants", 64'(grant_log.size()), 64'(2));
        chk("two_req_first", 64'(grant_log[0]), 64'(0));
        chk("two_req_second", 64'(grant_log[1]), 64'(1));
        chk("two_req_model_ptr", 64'(m_ptr), 64'(2));

        // Single engine 3, x=5 y=2 iter=0x2A, fresh frame
        fs_req = 1;
        cycle();
        eq[3].push_back(mk(5, 2, 8'h2A));
        ack_cyc.delete(); ack_val.delete(); we_log.delete();
        c0 = cyc + 1;
        run_idle(100);
        chk("e3_ack_count", 64'(ack_val.size()), 64'(2));
        chk("e3_ack_val0", 64'(ack_val[0]), 64'(16'h0008));
        chk("e3_ack_val1", 64'(ack_val[1]), 64'(16'h0008));
        chk("e3_ack_cycle", 64'(ack_cyc[0]), 64'(c0 + 1));
        chk("e3_we_cycle", 64'(we_log[0]), 64'(c0 + 3));
        chk("e3_fb_addr", 64'(addr), 64'(1285));
        chk("e3_model_addr", 64'(m_addr), 64'(1285));
        chk("e3_fb_data", 64'(data), 64'(8'h2A));
        chk("e3_pixel_count", 64'(pc), 64'(1));

        // Last pixel of the frame, then an out-of-range x
        eq[2].push_back(mk(639, V - 1, 8'h77));
        run_idle(100);
        chk("corner_fb_addr", 64'(addr), 64'(TOT - 1));
        chk("corner_fb_data", 64'(data), 64'(8'h77));
        chk("corner_pixel_count", 64'(pc), 64'(2));
        eq[2].push_back(mk(640, 0, 8'h11));
        we_log.delete();
        run_idle(100);
        chk("oor_no_write", 64'(we_log.size()), 64'(0));
        chk("oor_range_err", 64'(re), 64'(1));
        chk("oor_pixel_count", 64'(pc), 64'(2));
        chk("oor_addr_held", 64'(addr), 64'(TOT - 1));

        // Reset during CAPTURE of engine 7
        eq[7].push_back(mk(1, 1, 9));
        rst_at_capture = 1;
        we_log.delete();
        run_idle(100);
        chk("rst_no_write", 64'(we_log.size()), 64'(0));
        chk("rst_pixel_count", 64'(pc), 64'(0));
        chk("rst_fb_addr", 64'(addr), 64'(0));

        // All engines hold requests: strict rotation from pointer 0, one write per 5 cycles
        for (int i = 0; i < NE; i++) begin
            eq[i].push_back(mk($urandom_range(0, H - 1), $urandom_range(0, V - 1), $urandom_range(0, 255)));
            eq[i].push_back(mk($urandom_range(0, H - 1), $urandom_range(0, V - 1), $urandom_range(0, 255)));
        end
        grant_log.delete(); we_log.delete();
        run_idle(400);
        chk("rot_ngrants", 64'(grant_log.size()), 64'(2 * NE));
        for (int k = 0; k < grant_log.size(); k++) chk("rot_order", 64'(grant_log[k]), 64'(k % NE));
        for (int k = 1; k < we_log.size(); k++) chk("rot_we_spacing", 64'(we_log[k] - we_log[k-1]), 64'(5));

        // Randomized traffic with occasional frame_start pulses
        rnd_fs = 1;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0)
                eq[$urandom_range(0, NE - 1)].push_back(
                    mk($urandom_range(0, 700), $urandom_range(0, V + 1), $urandom_range(0, 255)));
            cycle();
        end
        rnd_fs = 0;
        run_idle(5000);

        // Fill a whole frame, then saturate
        fs_req = 1;
        cycle();
        for (int k = 0; k < TOT; k++) eq[k % NE].push_back(mk(k % H, k / H, k & 255));
        run_idle(20000);
        chk("frame_done_set", 64'(fd), 64'(1));
        chk("frame_full_count", 64'(pc), 64'(TOT));
        for (int k = 0; k < 3; k++) eq[k].push_back(mk(k, 0, 5));
        we_log.delete();
        run_idle(200);
        chk("sat_writes_issued", 64'(we_log.size()), 64'(3));
        chk("sat_count_held", 64'(pc), 64'(TOT));
        chk("sat_done_held", 64'(fd), 64'(1));

        // frame_start coincident with a write: the write belongs to the new frame
        fs_at_write = 1;
        eq[5].push_back(mk(3, 3, 8'h33));
        run_idle(100);
        chk("fs_write_count", 64'(pc), 64'(1));
        chk("fs_write_done", 64'(fd), 64'(0));

        // Plain frame_start clears everything
        eq[4].push_back(mk(H, 0, 1));
        run_idle(100);
        chk("pre_clear_err", 64'(re), 64'(1));
        fs_req = 1;
        cycle();
        cycle();
        chk("clear_count", 64'(pc), 64'(0));
        chk("clear_done", 64'(fd), 64'(0));
        chk("clear_err", 64'(re), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
